universal_shift_register: RTL

Parametrised universal shift register, successor to the fixed 4-bit bidirectional shifter. Executes multi-step commands from a valid/ready command port: logical/arithmetic shifts and rotates of `count` single-bit steps (one step per cycle), parallel load and clear. Sits between a control sequencer and serial/parallel datapaths, e.g. serialisers, LFSR-style scramblers and bit-stream alignment.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/usr_step_unit.sv | 46 ++++
 rtl/universal_shift_register.sv | 105 ++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes,
// FSM states and a helper that identifies single-bit step operations.
package usr_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'b000,
      OP_SHL   = 3'b001,
      OP_SHR   = 3'b010,
      OP_ROL   = 3'b011,
      OP_ROR   = 3'b100,
      OP_ASR   = 3'b101,
      OP_LOAD  = 3'b110,
      OP_CLEAR = 3'b111
   } usr_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } usr_state_e;

   function automatic logic is_step_op(usr_op_e op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) ||
             (op == OP_ROR) || (op == OP_ASR);
   endfunction

endpackage

// File: rtl/usr_step_unit.sv
// One single-bit shift/rotate step, purely combinational.
// Ports: op, d, shift_in in; d_next (stepped value), bit_out (expelled bit).
module usr_step_unit
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  usr_op_e          op,
   input  logic [WIDTH-1:0] d,
   input  logic             shift_in,
   output logic [WIDTH-1:0] d_next,
   output logic             bit_out
);

   always_comb begin
      d_next  = d;
      bit_out = 1'b0;
      unique case (op)
         OP_SHL: begin
            d_next  = {d[WIDTH-2:0], shift_in};
            bit_out = d[WIDTH-1];
         end
         OP_SHR: begin
            d_next  = {shift_in, d[WIDTH-1:1]};
            bit_out = d[0];
         end
         OP_ROL: begin
            d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
            bit_out = d[WIDTH-1];
         end
         OP_ROR: begin
            d_next  = {d[0], d[WIDTH-1:1]};
            bit_out = d[0];
         end
         OP_ASR: begin
            d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
            bit_out = d[0];
         end
         default: begin
            d_next  = d;
            bit_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register executing multi-step shift/rotate/load/clear commands.
// Ports: clk, reset, cmd_valid/ready/op/count/data, shift_in, pause, data_out,
// serial_out, busy, done.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             shift_in,
   input  logic             pause,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   usr_state_e       state_q, state_d;
   usr_op_e          op_q, op_d, step_op, in_op;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] data_d, step_data;
   logic             ser_d, step_bit;
   logic             accept;

   assign in_op     = usr_op_e'(cmd_op);
   assign cmd_ready = (state_q == S_IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

   // Step 1 runs on the accept edge from the live op; later steps use the latched op.
   assign step_op = (state_q == S_IDLE) ? in_op : op_q;

   usr_step_unit #(.WIDTH(WIDTH)) u_step (
      .op       (step_op),
      .d        (data_out),
      .shift_in (shift_in),
      .d_next   (step_data),
      .bit_out  (step_bit)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      data_d  = data_out;
      ser_d   = serial_out;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = in_op;
               state_d = S_DONE;
               if (is_step_op(in_op)) begin
                  if (cmd_count != '0) begin
                     data_d = step_data;
                     ser_d  = step_bit;
                     rem_d  = cmd_count - ONE;
                     if (cmd_count != ONE) state_d = S_SHIFT;
                  end
               end else if (in_op == OP_LOAD) begin
                  data_d = cmd_data;
               end else if (in_op == OP_CLEAR) begin
                  data_d = '0;
               end
            end
         end
         S_SHIFT: begin
            if (!pause) begin
               data_d = step_data;
               ser_d  = step_bit;
               rem_d  = rem_q - ONE;
               if (rem_q == ONE) state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_NOP;
         rem_q      <= '0;
         data_out   <= '0;
         serial_out <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rem_q      <= rem_d;
         data_out   <= data_d;
         serial_out <= ser_d;
      end
   end

endmodule
